// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and 27 MHz timing defaults for push-button conditioning.
package btn_pkg;
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;
    localparam int STABLE_CYCLES_DEF = 270000;
    localparam int REPEAT_DELAY_DEF  = 13500000;
    localparam int REPEAT_PERIOD_DEF = 5400000;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous pad inputs.
//   clk_in  destination clock
//   rst_in  asynchronous active-high reset, loads RST_VAL into both flops
//   d       asynchronous input
//   q       synchronised output
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) {q, meta} <= {2{RST_VAL}};
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: debounces an active-low push-button into a level plus press/release strobes.
//   clk_in         system clock (27 MHz)
//   rst_in         asynchronous active-high reset
//   btn_n_in       raw button pad, low = pressed
//   btn_level      debounced state, 1 = pressed
//   press_pulse    one-cycle strobe per accepted press (and per auto-repeat)
//   release_pulse  one-cycle strobe per accepted release
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat press strobes.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = 24,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_n_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic             s_n;
    btn_state_t       state, state_nxt, prev;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rpt_hit;
    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d      (btn_n_in),
        .q      (s_n)
    );
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            state <= RELEASED;
            prev  <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            prev  <= state;
            cnt   <= cnt_nxt;
        end
    // cnt_nxt defaults to 0, so every state change clears the counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            RELEASED:     if (!s_n) state_nxt = PRESS_WAIT;
            PRESS_WAIT:   if (s_n) state_nxt = RELEASED;
                          else if (cnt == LAST) state_nxt = PRESSED;
                          else cnt_nxt = cnt + 1'b1;
            PRESSED:      if (s_n) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: if (!s_n) state_nxt = PRESSED;
                          else if (cnt == LAST) state_nxt = RELEASED;
                          else cnt_nxt = cnt + 1'b1;
            default:      state_nxt = RELEASED;
        endcase
    end
`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [RPT_W-1:0] rcnt;
    logic             rpt_done;
    logic             rpt_wrap;
    // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD; leaving PRESSED restarts both.
    assign rpt_wrap = rcnt == (rpt_done ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1));
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in || state != PRESSED) begin
            rcnt     <= '0;
            rpt_done <= 1'b0;
            rpt_hit  <= 1'b0;
        end else begin
            rcnt     <= rpt_wrap ? '0 : rcnt + 1'b1;
            rpt_done <= rpt_done | rpt_wrap;
            rpt_hit  <= rpt_wrap;
        end
`else
    assign rpt_hit = 1'b0;
`endif
    // Strobes mark the first cycle after a qualified transition; returns from *_WAIT give none.
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            btn_level     <= state == PRESSED || state == RELEASE_WAIT;
            press_pulse   <= (state == PRESSED && prev == PRESS_WAIT) || rpt_hit;
            release_pulse <= state == RELEASED && prev == RELEASE_WAIT;
        end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed self-checking bench for btn_debounce with STABLE_CYCLES=4.
module tb_btn_debounce;
    localparam int S = 4;
    localparam int D = 10;
    localparam int P = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic btn_n_in = 1'b1;
    logic btn_level, press_pulse, release_pulse;
    int total = 0;
    int bad = 0;

    always #5 clk_in = ~clk_in;

    btn_debounce #(
        .STABLE_CYCLES (S),
        .CNT_W         (8),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .btn_n_in      (btn_n_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic test_reset();
        logic [2:0] want;
        rst_in = 1'b1;
        btn_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        total++;
        if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold: got %b want 000", {press_pulse, release_pulse, btn_level});
        end
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        btn_n_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        total++;
        if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_wait: got %b want 000", {press_pulse, release_pulse, btn_level});
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            want = {k == 7, 1'b0, k >= 7};
            total++;
            if ({press_pulse, release_pulse, btn_level} !== want) begin
                bad++;
                $display("FAIL reset_requalify k=%0d: got %b want %b", k, {press_pulse, release_pulse, btn_level}, want);
            end
        end
        #2 rst_in = 1'b1;
        #1;
        total++;
        if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
            bad++;
            $display("FAIL reset_async_pressed: got %b want 000", {press_pulse, release_pulse, btn_level});
        end
        @(negedge clk_in);
        btn_n_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_press();
        logic [2:0] want;
        btn_n_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            want = {k == 7, 1'b0, k >= 7};
            total++;
            if ({press_pulse, release_pulse, btn_level} !== want) begin
                bad++;
                $display("FAIL press k=%0d: got %b want %b", k, {press_pulse, release_pulse, btn_level}, want);
            end
        end
    endtask

    task automatic test_glitch();
        btn_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        btn_n_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            total++;
            if ({release_pulse, btn_level} !== 2'b01) begin
                bad++;
                $display("FAIL glitch k=%0d: got %b want 01", k, {release_pulse, btn_level});
            end
        end
    endtask

    task automatic test_release();
        logic [1:0] want;
        btn_n_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            want = {k == 7, k < 7};
            total++;
            if ({release_pulse, btn_level} !== want) begin
                bad++;
                $display("FAIL release k=%0d: got %b want %b", k, {release_pulse, btn_level}, want);
            end
        end
    endtask

    task automatic test_bounce();
        int runs[20] = '{1, 2, 3, 1, 1, 3, 2, 2, 3, 1, 2, 3, 1, 3, 2, 1, 2, 3, 2, 2};
        logic v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn_n_in = v;
            for (int j = 0; j < runs[i]; j++) begin
                @(negedge clk_in);
                total++;
                if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
                    bad++;
                    $display("FAIL bounce run=%0d: got %b want 000", i, {press_pulse, release_pulse, btn_level});
                end
            end
            v = ~v;
        end
        btn_n_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            total++;
            if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
                bad++;
                $display("FAIL bounce_settle k=%0d: got %b want 000", k, {press_pulse, release_pulse, btn_level});
            end
        end
    endtask

    task automatic test_repeat();
        logic [1:0] want;
        btn_n_in = 1'b0;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk_in);
            want = {k == 7 || (AR && k >= 7 + D && (k - 7 - D) % P == 0), k >= 7};
            total++;
            if ({press_pulse, btn_level} !== want) begin
                bad++;
                $display("FAIL repeat k=%0d: got %b want %b", k, {press_pulse, btn_level}, want);
            end
        end
        btn_n_in = 1'b1;
        repeat (12) @(negedge clk_in);
        total++;
        if ({press_pulse, release_pulse, btn_level} !== 3'b000) begin
            bad++;
            $display("FAIL repeat_end: got %b want 000", {press_pulse, release_pulse, btn_level});
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_bounce();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
